// File: rtl/adc_sync_capture_nx.sv
// Sync-framed ADC capture: two-stage registered data path with optional
// offset-binary to two's-complement conversion and an arm/lock/lost sync checker.
module adc_sync_capture_nx #(
  parameter int NCH   = 2,
  parameter int DEMUX = 4,
  parameter int BITS  = 12,
  parameter int PER_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                        adc_clk,
  input  logic                        adc_rst_n,
  input  logic [NCH*DEMUX*BITS-1:0]   data_in,
  input  logic                        sync_in,
  input  logic                        fmt_twos,
  input  logic                        arm,
  input  logic [PER_W-1:0]            expected_period,
  output logic [NCH*DEMUX*BITS-1:0]   data_out,
  output logic                        data_valid,
  output logic                        sync_out,
  output logic [1:0]                  state,
  output logic [CNT_W-1:0]            sync_count,
  output logic [PER_W-1:0]            last_period,
  output logic                        sync_err
);

  localparam int W  = NCH * DEMUX * BITS;
  localparam int NS = NCH * DEMUX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_LOCKED = 2'd2,
    S_LOST   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     data1_q, data2_q, data2_d;
  logic             sync1_q, sync_hist_q, arm1_q;
  logic             sync_out_q, valid_q, valid_d;
  logic [PER_W-1:0] pc_q, pc_d, lp_q, lp_d, pc_inc;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;
  logic [W-1:0]     msb_mask;
  logic             sync_edge, period_chk;

  always_comb begin
    msb_mask = '0;
    for (int i = 0; i < NS; i++) begin
      msb_mask[i*BITS + BITS - 1] = 1'b1;
    end
  end

  // arm is registered alongside sync_in so both reach the FSM on the same cycle.
  assign sync_edge  = sync1_q & ~sync_hist_q;
  assign period_chk = (expected_period != '0);
  assign data2_d    = data1_q ^ (fmt_twos ? msb_mask : '0);
  assign pc_inc     = (pc_q == '1) ? pc_q : pc_q + PER_W'(1);
  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    lp_d    = lp_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (arm1_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (sync_edge) begin
          state_d = S_LOCKED;
          cnt_d   = CNT_W'(1);
          pc_d    = PER_W'(1);
        end
      end
      S_LOCKED: begin
        pc_d = pc_inc;
        if (arm1_q) begin
          state_d = S_ARMED;
          err_d   = 1'b0;
          cnt_d   = '0;
        end else if (sync_edge && period_chk && (pc_q != expected_period)) begin
          state_d = S_LOST;
          err_d   = 1'b1;
          lp_d    = pc_q;
        end else if (sync_edge) begin
          lp_d  = pc_q;
          pc_d  = PER_W'(1);
          cnt_d = cnt_inc;
        end else if (period_chk && (pc_q == expected_period)) begin
          state_d = S_LOST;
          err_d   = 1'b1;
        end
      end
      S_LOST: begin
        if (arm1_q) begin
          state_d = S_ARMED;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign valid_d = (state_d == S_LOCKED);

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      data1_q     <= '0;
      sync1_q     <= 1'b0;
      sync_hist_q <= 1'b0;
      arm1_q      <= 1'b0;
      data2_q     <= '0;
      sync_out_q  <= 1'b0;
      valid_q     <= 1'b0;
      state_q     <= S_IDLE;
      pc_q        <= '0;
      cnt_q       <= '0;
      lp_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      data1_q     <= data_in;
      sync1_q     <= sync_in;
      sync_hist_q <= sync1_q;
      arm1_q      <= arm;
      data2_q     <= data2_d;
      sync_out_q  <= sync_edge;
      valid_q     <= valid_d;
      state_q     <= state_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      lp_q        <= lp_d;
      err_q       <= err_d;
    end
  end

  assign data_out    = data2_q;
  assign data_valid  = valid_q;
  assign sync_out    = sync_out_q;
  assign state       = state_q;
  assign sync_count  = cnt_q;
  assign last_period = lp_q;
  assign sync_err    = err_q;

endmodule

// File: tb/tb_adc_sync_capture_nx.sv
// Bench for adc_sync_capture_nx: each sync edge driven pushes its expected
// framed word and status into a queue that a monitor checks on sync_out.
module tb_adc_sync_capture_nx;

  localparam int W = 96;

  typedef struct packed {
    logic [W-1:0] data;
    logic         valid;
    logic [1:0]   st;
    logic [15:0]  cnt;
    logic [15:0]  lp;
    logic         err;
  } exp_t;

  logic          adc_clk = 1'b0;
  logic          adc_rst_n;
  logic [W-1:0]  data_in;
  logic          sync_in;
  logic          fmt_twos;
  logic          arm;
  logic [15:0]   expected_period;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic          sync_out;
  logic [1:0]    state;
  logic [15:0]   sync_count;
  logic [15:0]   last_period;
  logic          sync_err;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 adc_clk = ~adc_clk;

  adc_sync_capture_nx dut (
    .adc_clk         (adc_clk),
    .adc_rst_n       (adc_rst_n),
    .data_in         (data_in),
    .sync_in         (sync_in),
    .fmt_twos        (fmt_twos),
    .arm             (arm),
    .expected_period (expected_period),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .sync_out        (sync_out),
    .state           (state),
    .sync_count      (sync_count),
    .last_period     (last_period),
    .sync_err        (sync_err)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] d, input logic a);
    sync_in = s;
    data_in = d;
    arm     = a;
    @(posedge adc_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, {$urandom(), $urandom(), $urandom()}, 1'b0);
  endtask

  task automatic do_arm();
    drive(1'b0, '0, 1'b1);
    idle(3);
  endtask

  // One edge word, then sync low until the next edge 'gap' cycles later.
  task automatic send_edge(input logic [W-1:0] word, input logic [W-1:0] exp_data,
                           input logic arm_too, input int gap, input logic e_valid,
                           input logic [1:0] e_st, input logic [15:0] e_cnt,
                           input logic [15:0] e_lp, input logic e_err);
    exp_t e;
    e.data  = exp_data;
    e.valid = e_valid;
    e.st    = e_st;
    e.cnt   = e_cnt;
    e.lp    = e_lp;
    e.err   = e_err;
    exp_q.push_back(e);
    drive(1'b1, word, arm_too);
    idle(gap - 1);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge adc_clk);
      if (adc_rst_n && sync_out) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_sync_out: got 1 expected 0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("edge_data",  128'(data_out),    128'(e.data));
          chk("edge_valid", 128'(data_valid),  128'(e.valid));
          chk("edge_state", 128'(state),       128'(e.st));
          chk("edge_count", 128'(sync_count),  128'(e.cnt));
          chk("edge_lp",    128'(last_period), 128'(e.lp));
          chk("edge_err",   128'(sync_err),    128'(e.err));
        end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},  128'(data_out),    128'(0));
    chk({tag, "_valid"}, 128'(data_valid),  128'(0));
    chk({tag, "_sync"},  128'(sync_out),    128'(0));
    chk({tag, "_state"}, 128'(state),       128'(0));
    chk({tag, "_count"}, 128'(sync_count),  128'(0));
    chk({tag, "_lp"},    128'(last_period), 128'(0));
    chk({tag, "_err"},   128'(sync_err),    128'(0));
  endtask

  localparam logic [W-1:0] WA     = 96'h123456789ABCDEF012345678;
  localparam logic [W-1:0] WB     = 96'hFEDCBA987654321001234567;
  localparam logic [W-1:0] WC     = 96'h0F1E2D3C4B5A69788796A5B4;
  localparam logic [W-1:0] W800   = 96'h800800800800800800800800;
  localparam logic [W-1:0] WUNIQ  = 96'h8187075F64E53D42C31B20A1;
  localparam logic [W-1:0] WUNIQT = 96'h018F07DF6CE5BD4AC39B28A1;

  initial begin
    fork
      monitor();
    join_none

    adc_rst_n       = 1'b0;
    sync_in         = 1'b0;
    data_in         = '0;
    fmt_twos        = 1'b0;
    arm             = 1'b0;
    expected_period = 16'd64;
    idle(3);
    check_all_zero("reset");
    adc_rst_n = 1'b1;
    idle(2);

    // Arm and lock on a 64-cycle sync.
    do_arm();
    chk("armed_state", 128'(state), 128'(1));
    send_edge(WA, WA, 1'b0, 64, 1'b1, 2'd2, 16'd1, 16'd0, 1'b0);
    send_edge(WB, WB, 1'b0, 64, 1'b1, 2'd2, 16'd2, 16'd64, 1'b0);
    send_edge(WC, WC, 1'b0, 64, 1'b1, 2'd2, 16'd3, 16'd64, 1'b0);

    // Sample formatting and lane placement.
    fmt_twos = 1'b1;
    send_edge(W800, '0, 1'b0, 64, 1'b1, 2'd2, 16'd4, 16'd64, 1'b0);
    send_edge(WUNIQ, WUNIQT, 1'b0, 64, 1'b1, 2'd2, 16'd5, 16'd64, 1'b0);
    fmt_twos = 1'b0;
    send_edge(W800, W800, 1'b0, 64, 1'b1, 2'd2, 16'd6, 16'd64, 1'b0);
    send_edge(WUNIQ, WUNIQ, 1'b0, 63, 1'b1, 2'd2, 16'd7, 16'd64, 1'b0);

    // Early edge at pc=63, then an edge while LOST is ignored.
    send_edge(WA, WA, 1'b0, 20, 1'b0, 2'd3, 16'd7, 16'd63, 1'b1);
    send_edge(WB, WB, 1'b0, 10, 1'b0, 2'd3, 16'd7, 16'd63, 1'b1);

    // Re-arm, lock, then hold sync low: LOST exactly when pc reaches 64.
    do_arm();
    chk("rearm_state", 128'(state),      128'(1));
    chk("rearm_count", 128'(sync_count), 128'(0));
    chk("rearm_err",   128'(sync_err),   128'(0));
    send_edge(WC, WC, 1'b0, 65, 1'b1, 2'd2, 16'd1, 16'd63, 1'b0);
    chk("miss_pre_state", 128'(state),      128'(2));
    chk("miss_pre_valid", 128'(data_valid), 128'(1));
    idle(1);
    chk("miss_state", 128'(state),      128'(3));
    chk("miss_err",   128'(sync_err),   128'(1));
    chk("miss_valid", 128'(data_valid), 128'(0));
    chk("miss_lp",    128'(last_period), 128'(63));

    // Period check disabled: irregular intervals, then arm wins over an edge.
    expected_period = 16'd0;
    do_arm();
    chk("arm3_state", 128'(state), 128'(1));
    send_edge(WA, WA, 1'b0, 10, 1'b1, 2'd2, 16'd1, 16'd63, 1'b0);
    send_edge(WB, WB, 1'b0, 37, 1'b1, 2'd2, 16'd2, 16'd10, 1'b0);
    send_edge(WC, WC, 1'b0, 5,  1'b1, 2'd2, 16'd3, 16'd37, 1'b0);
    send_edge(WA, WA, 1'b0, 20, 1'b1, 2'd2, 16'd4, 16'd5, 1'b0);
    send_edge(WB, WB, 1'b1, 20, 1'b0, 2'd1, 16'd0, 16'd5, 1'b0);
    send_edge(WC, WC, 1'b0, 20, 1'b1, 2'd2, 16'd1, 16'd5, 1'b0);
    idle(5);

    // Asynchronous reset in the middle of a locked frame.
    chk("pre_reset_state", 128'(state), 128'(2));
    #3 adc_rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge adc_clk);
    @(posedge adc_clk);
    #4 adc_rst_n = 1'b1;
    @(posedge adc_clk);
    #1;
    idle(3);
    send_edge(WUNIQ, WUNIQ, 1'b0, 10, 1'b0, 2'd0, 16'd0, 16'd0, 1'b0);
    chk("post_reset_state", 128'(state), 128'(0));

    idle(5);
    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
